// File: rtl/tri_rasterizer_pkg.sv
// Shared widths, types and FSM state codes for the triangle rasterizer.
// Optional build macro: RASTERIZER_BACKFACE_CULL_EN (drops clockwise triangles).
package raster_pkg;

  localparam int unsigned COORD_W = 12;
  localparam int unsigned DEPTH_W = 16;
  localparam int unsigned EDGE_W  = 2 * COORD_W + 3;

  typedef logic signed [COORD_W-1:0] coord_t;
  typedef logic signed [DEPTH_W-1:0] depth_t;

  typedef struct packed {
    coord_t x;
    coord_t y;
    depth_t z;
  } vertex_t;

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] SETUP0 = 3'd1;
  localparam logic [2:0] SETUP1 = 3'd2;
  localparam logic [2:0] SCAN   = 3'd3;
  localparam logic [2:0] DRAIN  = 3'd4;

endpackage

// File: rtl/tri_rasterizer_if.sv
// Triangle-in / pixel-out handshake bundle of the rasterizer.
interface tri_rasterizer_if
  import raster_pkg::*;
#(
  parameter int unsigned XW = COORD_W,
  parameter int unsigned ZW = DEPTH_W,
  parameter int unsigned HW = 9,
  parameter int unsigned VW = 8
);
  logic                 valid_in;
  logic                 ready_out;
  logic [2:0][XW-1:0]   x;
  logic [2:0][XW-1:0]   y;
  logic [2:0][ZW-1:0]   z;
  logic                 valid_out;
  logic                 ready_in;
  logic [HW-1:0]        hcount;
  logic [VW-1:0]        vcount;
  logic [ZW-1:0]        z_out;
  logic                 done_out;

  modport master (
    output valid_in, x, y, z, ready_in,
    input  ready_out, valid_out, hcount, vcount, z_out, done_out
  );

  modport slave (
    input  valid_in, x, y, z, ready_in,
    output ready_out, valid_out, hcount, vcount, z_out, done_out
  );
endinterface

// File: rtl/tri_rasterizer_edge_stepper.sv
// One incremental edge function: holds A/B, row-start E and current E.
module edge_stepper
  import raster_pkg::*;
#(
  parameter int unsigned XW = COORD_W,
  parameter int unsigned EW = 2 * XW + 3
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              load_i,
  input  logic signed [XW:0] a_i,
  input  logic signed [XW:0] b_i,
  input  logic              init_i,
  input  logic              negate_i,
  input  logic signed [XW:0] dx_i,
  input  logic signed [XW:0] dy_i,
  input  logic              step_x_i,
  input  logic              step_row_i,
  output logic              covered_o
);
  logic signed [XW:0]   a_q, a_d, b_q, b_d;
  logic signed [EW-1:0] e_q, e_d, row_q, row_d, e_init;

  assign e_init = EW'(a_q) * EW'(dx_i) + EW'(b_q) * EW'(dy_i);

  always_comb begin
    a_d   = a_q;
    b_d   = b_q;
    e_d   = e_q;
    row_d = row_q;
    if (load_i) begin
      a_d = a_i;
      b_d = b_i;
    end else if (init_i) begin
      // Negating A, B and E together flips the winding without changing coverage.
      if (negate_i) begin
        a_d   = -a_q;
        b_d   = -b_q;
        e_d   = -e_init;
        row_d = -e_init;
      end else begin
        e_d   = e_init;
        row_d = e_init;
      end
    end else if (step_row_i) begin
      row_d = row_q + EW'(b_q);
      e_d   = row_q + EW'(b_q);
    end else if (step_x_i) begin
      e_d = e_q + EW'(a_q);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      a_q   <= '0;
      b_q   <= '0;
      e_q   <= '0;
      row_q <= '0;
    end else begin
      a_q   <= a_d;
      b_q   <= b_d;
      e_q   <= e_d;
      row_q <= row_d;
    end
  end

  assign covered_o = ~e_q[EW-1];
endmodule

// File: rtl/tri_rasterizer.sv
// Scan-converts one triangle over its clipped bbox, one position per cycle.
// Optional build macro: RASTERIZER_BACKFACE_CULL_EN.
module tri_rasterizer
  import raster_pkg::*;
#(
  parameter int unsigned XW      = COORD_W,
  parameter int unsigned ZW      = DEPTH_W,
  parameter int unsigned FB_HRES = 320,
  parameter int unsigned FB_VRES = 180
) (
  input logic             clk_in,
  input logic             rst_in,
  tri_rasterizer_if.slave bus
);
  localparam int unsigned EW = 2 * XW + 3;
  localparam int unsigned HW = $clog2(FB_HRES);
  localparam int unsigned VW = $clog2(FB_VRES);
  localparam logic signed [XW-1:0] X_LAST = XW'(FB_HRES - 1);
  localparam logic signed [XW-1:0] Y_LAST = XW'(FB_VRES - 1);

  logic [2:0]           state_q, state_d;
  logic signed [XW-1:0] vx_q [3];
  logic signed [XW-1:0] vx_d [3];
  logic signed [XW-1:0] vy_q [3];
  logic signed [XW-1:0] vy_d [3];
  logic signed [ZW-1:0] z0_q, z0_d;
  logic signed [XW-1:0] xmin_q, xmin_d, xmax_q, xmax_d, ymin_q, ymin_d, ymax_q, ymax_d;
  logic signed [XW-1:0] cx_q, cx_d, cy_q, cy_d;
  logic                 valid_q, valid_d, done_q, done_d, ready_q, ready_d;
  logic [HW-1:0]        hc_q, hc_d;
  logic [VW-1:0]        vc_q, vc_d;
  logic [ZW-1:0]        zo_q, zo_d;

  logic signed [XW:0]   ea [3];
  logic signed [XW:0]   eb [3];
  logic signed [XW:0]   edx [3];
  logic signed [XW:0]   edy [3];
  logic [2:0]           cov;
  logic                 load, init, step_x, step_row, negate, advance;

  for (genvar i = 0; i < 3; i++) begin : g_edge
    localparam int J = (i + 1) % 3;
    assign ea[i]  = (XW+1)'(vy_q[i]) - (XW+1)'(vy_q[J]);
    assign eb[i]  = (XW+1)'(vx_q[J]) - (XW+1)'(vx_q[i]);
    assign edx[i] = (XW+1)'(xmin_q) - (XW+1)'(vx_q[i]);
    assign edy[i] = (XW+1)'(ymin_q) - (XW+1)'(vy_q[i]);
    edge_stepper #(.XW(XW), .EW(EW)) u_edge (
      .clk_i      (clk_in),
      .rst_ni     (rst_in),
      .load_i     (load),
      .a_i        (ea[i]),
      .b_i        (eb[i]),
      .init_i     (init),
      .negate_i   (negate),
      .dx_i       (edx[i]),
      .dy_i       (edy[i]),
      .step_x_i   (step_x),
      .step_row_i (step_row),
      .covered_o  (cov[i])
    );
  end

  // Twice the signed area: edge (0,1) evaluated at vertex 2.
  logic signed [XW:0]   d2x, d2y;
  logic signed [EW-1:0] area2;
  logic                 empty_box, drop;
  assign d2x       = (XW+1)'(vx_q[2]) - (XW+1)'(vx_q[0]);
  assign d2y       = (XW+1)'(vy_q[2]) - (XW+1)'(vy_q[0]);
  assign area2     = EW'(ea[0]) * EW'(d2x) + EW'(eb[0]) * EW'(d2y);
  assign negate    = area2[EW-1];
  assign empty_box = (xmin_q > xmax_q) || (ymin_q > ymax_q);
`ifdef RASTERIZER_BACKFACE_CULL_EN
  assign drop = (area2 == '0) || area2[EW-1] || empty_box;
`else
  assign drop = (area2 == '0) || empty_box;
`endif

  logic signed [XW-1:0] mnx, mxx, mny, mxy;
  always_comb begin
    mnx = vx_q[0];
    mxx = vx_q[0];
    mny = vy_q[0];
    mxy = vy_q[0];
    for (int k = 1; k < 3; k++) begin
      if (vx_q[k] < mnx) mnx = vx_q[k];
      if (vx_q[k] > mxx) mxx = vx_q[k];
      if (vy_q[k] < mny) mny = vy_q[k];
      if (vy_q[k] > mxy) mxy = vy_q[k];
    end
  end

  assign advance = !valid_q || bus.ready_in;

  always_comb begin
    state_d  = state_q;
    vx_d     = vx_q;
    vy_d     = vy_q;
    z0_d     = z0_q;
    xmin_d   = xmin_q;
    xmax_d   = xmax_q;
    ymin_d   = ymin_q;
    ymax_d   = ymax_q;
    cx_d     = cx_q;
    cy_d     = cy_q;
    valid_d  = valid_q;
    hc_d     = hc_q;
    vc_d     = vc_q;
    zo_d     = zo_q;
    done_d   = 1'b0;
    load     = 1'b0;
    init     = 1'b0;
    step_x   = 1'b0;
    step_row = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.valid_in) begin
          for (int k = 0; k < 3; k++) begin
            vx_d[k] = bus.x[k];
            vy_d[k] = bus.y[k];
          end
          z0_d    = bus.z[0];
          state_d = SETUP0;
        end
      end
      SETUP0: begin
        load    = 1'b1;
        xmin_d  = mnx[XW-1] ? '0 : mnx;
        ymin_d  = mny[XW-1] ? '0 : mny;
        xmax_d  = (mxx > X_LAST) ? X_LAST : mxx;
        ymax_d  = (mxy > Y_LAST) ? Y_LAST : mxy;
        state_d = SETUP1;
      end
      SETUP1: begin
        cx_d = xmin_q;
        cy_d = ymin_q;
        if (drop) begin
          state_d = DRAIN;
        end else begin
          init    = 1'b1;
          state_d = SCAN;
        end
      end
      SCAN: begin
        if (advance) begin
          valid_d = &cov;
          hc_d    = HW'(cx_q);
          vc_d    = VW'(cy_q);
          zo_d    = z0_q;
          if (cx_q == xmax_q) begin
            if (cy_q == ymax_q) begin
              state_d = DRAIN;
            end else begin
              step_row = 1'b1;
              cx_d     = xmin_q;
              cy_d     = cy_q + XW'(1);
            end
          end else begin
            step_x = 1'b1;
            cx_d   = cx_q + XW'(1);
          end
        end
      end
      DRAIN: begin
        if (advance) begin
          valid_d = 1'b0;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state_q <= IDLE;
      for (int k = 0; k < 3; k++) begin
        vx_q[k] <= '0;
        vy_q[k] <= '0;
      end
      z0_q    <= '0;
      xmin_q  <= '0;
      xmax_q  <= '0;
      ymin_q  <= '0;
      ymax_q  <= '0;
      cx_q    <= '0;
      cy_q    <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      ready_q <= 1'b1;
      hc_q    <= '0;
      vc_q    <= '0;
      zo_q    <= '0;
    end else begin
      state_q <= state_d;
      vx_q    <= vx_d;
      vy_q    <= vy_d;
      z0_q    <= z0_d;
      xmin_q  <= xmin_d;
      xmax_q  <= xmax_d;
      ymin_q  <= ymin_d;
      ymax_q  <= ymax_d;
      cx_q    <= cx_d;
      cy_q    <= cy_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      ready_q <= ready_d;
      hc_q    <= hc_d;
      vc_q    <= vc_d;
      zo_q    <= zo_d;
    end
  end

  assign bus.ready_out = ready_q;
  assign bus.valid_out = valid_q;
  assign bus.hcount    = hc_q;
  assign bus.vcount    = vc_q;
  assign bus.z_out     = zo_q;
  assign bus.done_out  = done_q;
endmodule

// File: tb/tb_tri_rasterizer.sv
// Directed self-checking bench for tri_rasterizer (default 320x180 framebuffer).
module tb_tri_rasterizer;
  localparam int unsigned XW      = 12;
  localparam int unsigned ZW      = 16;
  localparam int unsigned FB_HRES = 320;
  localparam int unsigned FB_VRES = 180;
  localparam int unsigned HW      = $clog2(FB_HRES);
  localparam int unsigned VW      = $clog2(FB_VRES);

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   failures = 0;
  int   done_cnt = 0;
  int   qh[$], qv[$], qz[$];
  int   eh[$], ev[$];
  int   exp_z;
  int   n_done, n_first, d0;
  logic seen;

  tri_rasterizer_if #(.XW(XW), .ZW(ZW), .HW(HW), .VW(VW)) bus ();

  tri_rasterizer #(.XW(XW), .ZW(ZW), .FB_HRES(FB_HRES), .FB_VRES(FB_VRES)) dut (
    .clk_in (clk),
    .rst_in (rst_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  // Pixel and done-pulse capture at each handshake edge.
  always @(posedge clk) begin
    if (bus.valid_out && bus.ready_in) begin
      qh.push_back(int'(bus.hcount));
      qv.push_back(int'(bus.vcount));
      qz.push_back(int'($signed(bus.z_out)));
    end
    if (bus.done_out) done_cnt++;
  end

  task automatic chk(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic drive_tri(input int x0, input int y0, input int x1, input int y1,
                           input int x2, input int y2, input int z0);
    @(negedge clk);
    chk("ready_before_send", bus.ready_out, 1);
    bus.x[0] = XW'(x0); bus.y[0] = XW'(y0);
    bus.x[1] = XW'(x1); bus.y[1] = XW'(y1);
    bus.x[2] = XW'(x2); bus.y[2] = XW'(y2);
    bus.z[0] = ZW'(z0); bus.z[1] = ZW'(z0 + 1); bus.z[2] = ZW'(z0 + 2);
    bus.valid_in = 1'b1;
    @(negedge clk);
    bus.valid_in = 1'b0;
  endtask

  task automatic wait_done(input string tag, output int nd, output int nf);
    int dc;
    dc = done_cnt;
    nd = 0;
    nf = -1;
    for (int i = 1; i <= 2000; i++) begin
      @(negedge clk);
      if (bus.valid_out && nf < 0) nf = i;
      if (bus.done_out) begin
        nd = i;
        break;
      end
    end
    if (nd == 0) chk({tag, "_done_timeout"}, 0, 1);
    @(negedge clk);
    chk({tag, "_done_pulse_width"}, bus.done_out, 0);
    chk({tag, "_ready_after"}, bus.ready_out, 1);
    chk({tag, "_done_count"}, done_cnt - dc, 1);
  endtask

  task automatic cmp_pix(input string tag);
    chk({tag, "_count"}, qh.size(), eh.size());
    for (int i = 0; i < eh.size() && i < qh.size(); i++) begin
      chk({tag, "_h"}, qh[i], eh[i]);
      chk({tag, "_v"}, qv[i], ev[i]);
      chk({tag, "_z"}, qz[i], exp_z);
      chk({tag, "_h_in_fb"}, (qh[i] < int'(FB_HRES)), 1);
      chk({tag, "_v_in_fb"}, (qv[i] < int'(FB_VRES)), 1);
    end
  endtask

  task automatic clear_q();
    qh.delete(); qv.delete(); qz.delete(); eh.delete(); ev.delete();
  endtask

  task automatic set_tri_a();
    eh = '{0, 1, 2, 3, 0, 1, 2, 0, 1, 0};
    ev = '{0, 0, 0, 0, 1, 1, 1, 2, 2, 3};
  endtask

  initial begin
    rst_n = 1'b0;
    bus.valid_in = 1'b0;
    bus.ready_in = 1'b1;
    bus.x = '0; bus.y = '0; bus.z = '0;
    repeat (2) @(negedge clk);
    chk("rst_ready", bus.ready_out, 1);
    chk("rst_valid", bus.valid_out, 0);
    chk("rst_done", bus.done_out, 0);
    chk("rst_hcount", bus.hcount, 0);
    chk("rst_vcount", bus.vcount, 0);
    chk("rst_zout", bus.z_out, 0);
    rst_n = 1'b1;

    // Basic right triangle, CCW.
    clear_q(); set_tri_a(); exp_z = 100;
    drive_tri(0, 0, 3, 0, 0, 3, 100);
    wait_done("tri_a", n_done, n_first);
    chk("tri_a_first_valid_latency", n_first, 3);
    cmp_pix("tri_a");

    // Reversed winding.
    clear_q(); exp_z = 100;
    drive_tri(0, 0, 0, 3, 3, 0, 100);
    wait_done("tri_rev", n_done, n_first);
`ifdef RASTERIZER_BACKFACE_CULL_EN
    chk("tri_rev_cull_done_latency", n_done, 3);
`else
    set_tri_a();
`endif
    cmp_pix("tri_rev");

    // Degenerate (collinear).
    clear_q(); exp_z = 9;
    drive_tri(0, 0, 2, 2, 4, 4, 9);
    wait_done("degen", n_done, n_first);
    chk("degen_done_latency", n_done, 3);
    cmp_pix("degen");

    // Clipped bbox with no covered pixels inside.
    clear_q(); exp_z = 7;
    drive_tri(-5, -5, 2, -5, -5, 2, 7);
    wait_done("clip_empty", n_done, n_first);
    cmp_pix("clip_empty");

    // Clipped bbox, x+y<=2, negative depth.
    clear_q(); exp_z = -3;
    eh = '{0, 1, 2, 0, 1, 0};
    ev = '{0, 0, 0, 1, 1, 2};
    drive_tri(-2, -2, 4, -2, -2, 4, -3);
    wait_done("clip6", n_done, n_first);
    cmp_pix("clip6");

    // Clipping at the far framebuffer corner.
    clear_q(); exp_z = 55;
    for (int yy = 170; yy < 180; yy++)
      for (int xx = 310; xx < 320; xx++) begin
        eh.push_back(xx);
        ev.push_back(yy);
      end
    drive_tri(310, 170, 330, 170, 310, 190, 55);
    wait_done("clip_far", n_done, n_first);
    cmp_pix("clip_far");

    // Backpressure while (1,0) is presented.
    clear_q(); set_tri_a(); exp_z = 100;
    drive_tri(0, 0, 3, 0, 0, 3, 100);
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      if (bus.valid_out && bus.hcount == HW'(1) && bus.vcount == VW'(0)) seen = 1'b1;
    end
    chk("stall_reach_pixel", seen, 1);
    bus.ready_in = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_hcount", bus.hcount, 1);
      chk("stall_vcount", bus.vcount, 0);
      chk("stall_valid", bus.valid_out, 1);
    end
    bus.ready_in = 1'b1;
    wait_done("stall", n_done, n_first);
    cmp_pix("stall");

    // Reset in the middle of a scan.
    clear_q();
    drive_tri(0, 0, 3, 0, 0, 3, 100);
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      if (bus.valid_out) seen = 1'b1;
    end
    chk("midscan_reach_scan", seen, 1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_ready", bus.ready_out, 1);
    chk("midrst_valid", bus.valid_out, 0);
    chk("midrst_done", bus.done_out, 0);
    chk("midrst_hcount", bus.hcount, 0);
    chk("midrst_vcount", bus.vcount, 0);
    chk("midrst_zout", bus.z_out, 0);
    rst_n = 1'b1;
    d0 = done_cnt;
    repeat (6) @(negedge clk);
    chk("midrst_no_done", done_cnt - d0, 0);
    clear_q(); exp_z = 42;
    eh = '{0, 1, 2, 0, 1, 0};
    ev = '{0, 0, 0, 1, 1, 2};
    drive_tri(-2, -2, 4, -2, -2, 4, 42);
    wait_done("after_rst", n_done, n_first);
    cmp_pix("after_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
